// File: rtl/pc_gen_if.sv
// Fetch-redirect bus between the execute stage (master) and the PC generator (slave).
// The slave returns the fetch address, pending status and return-stack status.
interface pc_gen_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             redirect;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] tgt_addr;
  logic [WIDTH-1:0] link_addr;
  logic [WIDTH-1:0] pc_out;
  logic             pend;
  logic [CW-1:0]    ras_count;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, redirect, call, ret, tgt_addr, link_addr,
    input  pc_out, pend, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, redirect, call, ret, tgt_addr, link_addr,
    output pc_out, pend, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with held redirects and a circular
// return-address stack.
module pc_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RST_VEC   = '1,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int unsigned   PW   = $clog2(RAS_DEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic {RUN, HELD} pend_state_t;

  pend_state_t      state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_addr;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [CW-1:0]    ras_cnt;
  logic             ovf_q;
  logic             unf_q;

  logic             take_call;
  logic             take_redir;
  logic             take_ret;
  logic             ret_empty;
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt;
  logic [PW-1:0]    top_idx;
  logic             ras_full;

  // ras_ptr is the next write slot; when full it also names the oldest entry,
  // so a push simply overwrites it.
  always_comb begin
    top_idx    = ras_ptr - PW'(1);
    ras_full   = (ras_cnt == FULL);
    take_call  = bus.call;
    take_redir = !bus.call && bus.redirect;
    take_ret   = !bus.call && !bus.redirect && bus.ret && (ras_cnt != '0);
    ret_empty  = !bus.call && !bus.redirect && bus.ret && (ras_cnt == '0);
    tgt_valid  = take_call || take_redir || take_ret;
    tgt        = take_ret ? ras_mem[top_idx] : bus.tgt_addr;
  end

  always_ff @(posedge clk) begin
    if (take_call) begin
      ras_mem[ras_ptr] <= bus.link_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (take_call) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (ras_full) begin
          ovf_q <= 1'b1;
        end else begin
          ras_cnt <= ras_cnt + CW'(1);
        end
      end else if (take_ret) begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - CW'(1);
      end
      if (ret_empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc_q      <= RST_VEC;
      pend_addr <= RST_VEC;
    end else if (bus.stall) begin
      if (tgt_valid) begin
        pend_addr <= tgt;
        state     <= HELD;
      end
    end else begin
      state <= RUN;
      if (tgt_valid) begin
        pc_q <= tgt;
      end else if (state == HELD) begin
        pc_q <= pend_addr;
      end else begin
        pc_q <= pc_q + WIDTH'(1);
      end
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.pend      = (state == HELD);
  assign bus.ras_count = ras_cnt;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a queue-based reference model checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_pc_gen;
  logic clk;
  logic rst;

  pc_gen_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

  pc_gen #(.WIDTH(16), .RST_VEC(16'hFFFF), .RAS_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic [15:0] m_pc;
  logic        m_pend;
  logic [15:0] m_paddr;
  logic [15:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic model_reset();
    m_pc = 16'hFFFF; m_pend = 1'b0; m_paddr = 16'hFFFF;
    m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      lit("model_pc",   32'(bus.pc_out),    32'(m_pc));
      lit("model_pend", 32'(bus.pend),      32'(m_pend));
      lit("model_cnt",  32'(bus.ras_count), 32'(m_ras.size()));
      lit("model_ovf",  32'(bus.ras_ovf),   32'(m_ovf));
      lit("model_unf",  32'(bus.ras_unf),   32'(m_unf));
    end
  end

  // One clock cycle of stimulus; the model commits on the same edge as the DUT.
  task automatic step(input logic s, input logic r, input logic c, input logic t,
                      input logic [15:0] ta, input logic [15:0] la);
    logic        valid;
    logic [15:0] target;
    logic [15:0] n_pc;
    logic        n_pend;
    logic [15:0] n_paddr;
    bus.stall = s; bus.redirect = r; bus.call = c; bus.ret = t;
    bus.tgt_addr = ta; bus.link_addr = la;
    valid = 1'b0; target = 16'h0;
    n_pc = m_pc; n_pend = m_pend; n_paddr = m_paddr;
    @(posedge clk);
    if (c) begin
      valid = 1'b1; target = ta;
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(la);
    end else if (r) begin
      valid = 1'b1; target = ta;
    end else if (t) begin
      if (m_ras.size() > 0) begin
        valid = 1'b1; target = m_ras.pop_back();
      end else begin
        m_unf = 1'b1;
      end
    end
    if (!s) begin
      if (valid)       n_pc = target;
      else if (m_pend) n_pc = m_paddr;
      else             n_pc = m_pc + 16'd1;
      n_pend = 1'b0;
    end else if (valid) begin
      n_paddr = target; n_pend = 1'b1;
    end
    m_pc = n_pc; m_pend = n_pend; m_paddr = n_paddr;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.tgt_addr = '0; bus.link_addr = '0;
    model_reset();
    #3;
    lit("rst_pc",   32'(bus.pc_out),    32'hFFFF);
    lit("rst_pend", 32'(bus.pend),      32'h0);
    lit("rst_cnt",  32'(bus.ras_count), 32'h0);
    #4;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset and increment
    idle(); lit("inc0", 32'(bus.pc_out), 32'h0000);
    idle(); lit("inc1", 32'(bus.pc_out), 32'h0001);
    idle(); lit("inc2", 32'(bus.pc_out), 32'h0002);

    // Stalled redirects: newest captured target wins
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    lit("pc_0010", 32'(bus.pc_out), 32'h0010);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    lit("stall_hold", 32'(bus.pc_out), 32'h0010);
    lit("stall_pend", 32'(bus.pend),   32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    lit("still_held", 32'(bus.pc_out), 32'h0010);
    idle();
    lit("pend_apply",  32'(bus.pc_out), 32'h0080);
    lit("pend_clear",  32'(bus.pend),   32'h0);
    idle();
    lit("after_pend",  32'(bus.pc_out), 32'h0081);

    // New redirect beats the pending one
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0);
    lit("beat_pc",   32'(bus.pc_out), 32'h0200);
    lit("beat_pend", 32'(bus.pend),   32'h0);
    idle();
    lit("beat_next", 32'(bus.pc_out), 32'h0201);

    // Call / return, with a ret dropped by a coincident redirect
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0021);
    lit("call1_pc", 32'(bus.pc_out), 32'h0100); lit("call1_cnt", 32'(bus.ras_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0180, 16'h0105);
    lit("call2_pc", 32'(bus.pc_out), 32'h0180); lit("call2_cnt", 32'(bus.ras_count), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    lit("ret1_pc",  32'(bus.pc_out), 32'h0105); lit("ret1_cnt",  32'(bus.ras_count), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0400, 16'h0);
    lit("drop_pc",  32'(bus.pc_out), 32'h0400); lit("drop_cnt",  32'(bus.ras_count), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    lit("ret2_pc",  32'(bus.pc_out), 32'h0021); lit("ret2_cnt",  32'(bus.ras_count), 32'd0);

    // RAS overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0300 + 16'(i), 16'(i));
    end
    lit("full_cnt", 32'(bus.ras_count), 32'd4);
    lit("ovf",      32'(bus.ras_ovf),   32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      lit("ret_link", 32'(bus.pc_out), 32'(5 - i));
    end
    lit("unf_pre", 32'(bus.ras_unf), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    lit("unf",      32'(bus.ras_unf), 32'h1);
    lit("unf_inc",  32'(bus.pc_out),  32'h0003);
    lit("ovf_keep", 32'(bus.ras_ovf), 32'h1);

    // Stalled ret pops immediately, then async reset mid-stall
    pulse_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0500, 16'h000A);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0600, 16'h000B);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0700, 16'h000C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    lit("sret_cnt",  32'(bus.ras_count), 32'd2);
    lit("sret_pend", 32'(bus.pend),      32'h1);
    lit("sret_hold", 32'(bus.pc_out),    32'h0700);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    lit("arst_pc",   32'(bus.pc_out),    32'hFFFF);
    lit("arst_pend", 32'(bus.pend),      32'h0);
    lit("arst_cnt",  32'(bus.ras_count), 32'h0);
    lit("arst_ovf",  32'(bus.ras_ovf),   32'h0);
    lit("arst_unf",  32'(bus.ras_unf),   32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    bus.stall = 1'b0; bus.ret = 1'b0;
    idle();
    lit("post_rst_pc", 32'(bus.pc_out), 32'h0000);
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
